uart_tx_fifo: RTL and testbench

//  Parametrised UART transmitter with an input FIFO and a valid/ready write port.

---
 rtl/uart_tx_fifo.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter fed by a valid/ready write FIFO.
// Frames (start, data LSB first, optional parity, one or two stops) leave the FIFO back-to-back.
module uart_tx_fifo #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int DIV_OVERRIDE = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic [1:0]                    parity_type,
    input  logic [1:0]                    baud_sel,
    input  logic                          stop_two,
    output logic                          data_tx,
    output logic                          active_flag,
    output logic                          done_flag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          fifo_empty
);

    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int DIV_2400  = (CLK_FREQ + 1200) / 2400;
    localparam int DIV_4800  = (CLK_FREQ + 2400) / 4800;
    localparam int DIV_9600  = (CLK_FREQ + 4800) / 9600;
    localparam int DIV_19200 = (CLK_FREQ + 9600) / 19200;
    localparam int DIV_MAX   = (DIV_OVERRIDE != 0) ? DIV_OVERRIDE : DIV_2400;
    localparam int BAUD_W    = $clog2(DIV_MAX + 1);
    localparam int BIT_W     = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Clocks per bit for a baud selection; the override wins for every selection.
    function automatic logic [BAUD_W-1:0] div_for(input logic [1:0] sel);
        logic [BAUD_W-1:0] div_v;
        if (DIV_OVERRIDE != 0) begin
            div_v = BAUD_W'(DIV_OVERRIDE);
        end else begin
            case (sel)
                2'b00:   div_v = BAUD_W'(DIV_2400);
                2'b01:   div_v = BAUD_W'(DIV_4800);
                2'b10:   div_v = BAUD_W'(DIV_9600);
                default: div_v = BAUD_W'(DIV_19200);
            endcase
        end
        return div_v;
    endfunction

    // Odd parity makes the total count of ones odd, even parity makes it even.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic [1:0] pt);
        logic p_v;
        if (pt == 2'b01) begin
            p_v = ~(^d);
        end else begin
            p_v = ^d;
        end
        return p_v;
    endfunction

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic                 full_r;
    logic                 empty_r;

    state_t               state_r;
    logic                 data_tx_r;
    logic                 active_r;
    logic                 done_r;
    logic [BAUD_W-1:0]    baud_cnt_r;
    logic [BAUD_W-1:0]    div_r;
    logic [BIT_W-1:0]     bit_idx_r;
    logic                 stop_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 parity_r;
    logic                 has_par_r;
    logic                 stop_two_r;

    logic                 push_s;
    logic                 pop_s;
    logic                 bit_end_s;
    logic                 frame_end_s;

    // Handshake, bit-period end and pop decisions for the current cycle.
    always_comb begin
        push_s      = s_valid && !full_r;
        bit_end_s   = (baud_cnt_r == (div_r - BAUD_W'(1)));
        frame_end_s = 1'b0;
        if ((state_r == ST_STOP) && bit_end_s && (!stop_two_r || stop_idx_r)) begin
            frame_end_s = 1'b1;
        end else begin
            frame_end_s = 1'b0;
        end
        pop_s = !empty_r && ((state_r == ST_IDLE) || frame_end_s);
    end

    // FIFO storage; contents need no reset because the pointers qualify them.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= s_data;
        end
    end

    // FIFO pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10: begin
                    count_r <= count_r + CNT_W'(1);
                    full_r  <= (count_r == CNT_W'(FIFO_DEPTH - 1));
                    empty_r <= 1'b0;
                end
                2'b01: begin
                    count_r <= count_r - CNT_W'(1);
                    full_r  <= 1'b0;
                    empty_r <= (count_r == CNT_W'(1));
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    // Frame sequencer: latches word and configuration on pop, then shifts bits out.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            data_tx_r  <= 1'b1;
            active_r   <= 1'b0;
            done_r     <= 1'b0;
            baud_cnt_r <= '0;
            div_r      <= '0;
            bit_idx_r  <= '0;
            stop_idx_r <= 1'b0;
            shift_r    <= '0;
            parity_r   <= 1'b0;
            has_par_r  <= 1'b0;
            stop_two_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (pop_s) begin
                shift_r    <= mem_r[rd_ptr_r];
                parity_r   <= parity_bit(mem_r[rd_ptr_r], parity_type);
                has_par_r  <= (parity_type == 2'b01) || (parity_type == 2'b10);
                stop_two_r <= stop_two;
                div_r      <= div_for(baud_sel);
            end
            if ((state_r == ST_IDLE) || bit_end_s) begin
                baud_cnt_r <= '0;
            end else begin
                baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
            end
            case (state_r)
                ST_IDLE: begin
                    data_tx_r <= 1'b1;
                    active_r  <= 1'b0;
                    if (pop_s) begin
                        state_r   <= ST_START;
                        data_tx_r <= 1'b0;
                        active_r  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_r   <= ST_DATA;
                        data_tx_r <= shift_r[0];
                        bit_idx_r <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        if (bit_idx_r == BIT_W'(DATA_BITS - 1)) begin
                            if (has_par_r) begin
                                state_r   <= ST_PARITY;
                                data_tx_r <= parity_r;
                            end else begin
                                state_r    <= ST_STOP;
                                data_tx_r  <= 1'b1;
                                stop_idx_r <= 1'b0;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + BIT_W'(1);
                            shift_r   <= shift_r >> 1;
                            data_tx_r <= shift_r[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end_s) begin
                        state_r    <= ST_STOP;
                        data_tx_r  <= 1'b1;
                        stop_idx_r <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (frame_end_s) begin
                        done_r <= 1'b1;
                        if (pop_s) begin
                            state_r   <= ST_START;
                            data_tx_r <= 1'b0;
                        end else begin
                            state_r  <= ST_IDLE;
                            active_r <= 1'b0;
                        end
                    end else if (bit_end_s) begin
                        stop_idx_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    data_tx_r <= 1'b1;
                    active_r  <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready     = !full_r;
    assign data_tx     = data_tx_r;
    assign active_flag = active_r;
    assign done_flag   = done_r;
    assign fifo_count  = count_r;
    assign fifo_full   = full_r;
    assign fifo_empty  = empty_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: two instances (fixed divisor / real baud table),
// expected frames queued at push time and checked by a line monitor.
module tb_uart_tx_fifo;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       s_valid = 1'b0;
    logic       sel_b   = 1'b0;
    logic [7:0] s_data  = 8'h00;
    logic [1:0] ptype   = 2'b00;
    logic [1:0] bsel    = 2'b10;
    logic       stop2   = 1'b0;

    int cyc          = 0;
    int compared     = 0;
    int mismatched   = 0;
    int done_cnt     = 0;
    int idle_act_err = 0;
    int mon_pos      = -1;
    bit mon_pend     = 1'b0;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          div;
        int          push_cyc;
    } frame_t;

    frame_t exp_q[$];

    logic       valid_a, ready_a, tx_a, act_a, done_a, full_a, empty_a;
    logic [4:0] count_a;
    logic       valid_b, ready_b, tx_b, act_b, done_b, full_b, empty_b;
    logic [2:0] count_b;
    logic       tx_s, act_s, done_s, ready_s;

    assign valid_a = s_valid && !sel_b;
    assign valid_b = s_valid && sel_b;
    assign tx_s    = sel_b ? tx_b : tx_a;
    assign act_s   = sel_b ? act_b : act_a;
    assign done_s  = sel_b ? done_b : done_a;
    assign ready_s = sel_b ? ready_b : ready_a;

    uart_tx_fifo #(.CLK_FREQ(100_000_000), .DATA_BITS(8), .FIFO_DEPTH(16), .DIV_OVERRIDE(16)) dut_a (
        .clock(clk), .reset(reset), .s_valid(valid_a), .s_ready(ready_a), .s_data(s_data),
        .parity_type(ptype), .baud_sel(bsel), .stop_two(stop2), .data_tx(tx_a),
        .active_flag(act_a), .done_flag(done_a), .fifo_count(count_a), .fifo_full(full_a),
        .fifo_empty(empty_a)
    );

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .DATA_BITS(7), .FIFO_DEPTH(4), .DIV_OVERRIDE(0)) dut_b (
        .clock(clk), .reset(reset), .s_valid(valid_b), .s_ready(ready_b), .s_data(s_data[6:0]),
        .parity_type(ptype), .baud_sel(bsel), .stop_two(stop2), .data_tx(tx_b),
        .active_flag(act_b), .done_flag(done_b), .fifo_count(count_b), .fifo_full(full_b),
        .fifo_empty(empty_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame from the line protocol rules, using the configuration in force now.
    function automatic frame_t build_frame(input logic [7:0] d, input int pc);
        frame_t f;
        int n, ones, dbits, rate;
        dbits  = sel_b ? 7 : 8;
        f.bits = '0;
        n      = 1;
        ones   = 0;
        for (int i = 0; i < dbits; i++) begin
            f.bits[n] = d[i];
            if (d[i]) ones++;
            n++;
        end
        if (ptype == 2'b01) begin
            f.bits[n] = ((ones % 2) == 0);
            n++;
        end else if (ptype == 2'b10) begin
            f.bits[n] = ((ones % 2) == 1);
            n++;
        end
        f.bits[n] = 1'b1;
        n++;
        if (stop2) begin
            f.bits[n] = 1'b1;
            n++;
        end
        rate       = 2400 << bsel;
        f.div      = sel_b ? (1_000_000 + rate / 2) / rate : 16;
        f.nbits    = n;
        f.push_cyc = pc;
        return f;
    endfunction

    initial begin : monitor
        frame_t      cur;
        logic [15:0] got;
        bit          glitch, act_err, early, late_rep, junk, was_pend;
        int          b, w;
        got = '0; glitch = 1'b0; act_err = 1'b0; early = 1'b0;
        late_rep = 1'b0; junk = 1'b0; was_pend = 1'b0;
        cur.bits = '0; cur.nbits = 0; cur.div = 1; cur.push_cyc = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_pos  = -1;
                mon_pend = 1'b0;
                exp_q.delete();
                late_rep = 1'b0;
                junk     = 1'b0;
            end else begin
                was_pend = mon_pend;
                if (done_s === 1'b1) done_cnt++;
                if (mon_pend) begin
                    check("done_pulse", 32'(done_s), 1);
                    mon_pend = 1'b0;
                end
                if (mon_pos < 0) begin
                    if (tx_s === 1'b1) begin
                        junk = 1'b0;
                        if (act_s !== 1'b0) idle_act_err++;
                        if (exp_q.size() > 0 && !late_rep && cyc > exp_q[0].push_cyc + 1) begin
                            check("start_on_time", cyc, exp_q[0].push_cyc + 1);
                            late_rep = 1'b1;
                        end
                    end else if (!junk) begin
                        check("frame_expected", 32'(exp_q.size() > 0), 1);
                        if (exp_q.size() == 0) begin
                            junk = 1'b1;
                        end else begin
                            cur = exp_q.pop_front();
                            if (!was_pend && !late_rep) check("start_latency", cyc, cur.push_cyc + 1);
                            mon_pos = 0; got = '0; glitch = 1'b0; act_err = 1'b0;
                            early = 1'b0; late_rep = 1'b0;
                        end
                    end
                end
                if (mon_pos >= 0) begin
                    b = mon_pos / cur.div;
                    w = mon_pos % cur.div;
                    if (w == 0) got[b] = tx_s;
                    else if (tx_s !== got[b]) glitch = 1'b1;
                    if (act_s !== 1'b1) act_err = 1'b1;
                    if (mon_pos > 0 && done_s !== 1'b0) early = 1'b1;
                    mon_pos++;
                    if (mon_pos == cur.nbits * cur.div) begin
                        check("frame_bits", 32'(got), 32'(cur.bits));
                        check("bit_width_stable", 32'(glitch), 0);
                        check("active_during_frame", 32'(act_err), 0);
                        check("no_early_done", 32'(early), 0);
                        mon_pos  = -1;
                        mon_pend = 1'b1;
                    end
                end
            end
        end
    end

    task automatic push_word(input logic [7:0] d);
        int n;
        n       = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (ready_s !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) check("push_accept", 32'(ready_s), 1);
        else exp_q.push_back(build_frame(d, cyc + 1));
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_pos >= 0 || mon_pend) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", 32'(n < maxc), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_pos(input int target, input int maxc);
        int n;
        n = 0;
        while (mon_pos < target && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("reach_frame_pos", 32'(n < maxc), 1);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int d0, n;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx_a), 1);
        check("rst_ready", 32'(ready_a), 1);
        check("rst_empty", 32'(empty_a), 1);
        check("rst_full", 32'(full_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_active", 32'(act_a), 0);
        check("rst_count", 32'(count_a), 0);
        check("rst_tx_b", 32'(tx_b), 1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // single frame, no parity, one stop
        d0 = done_cnt;
        push_word(8'hA5);
        wait_drain(400);
        check("single_done_count", done_cnt - d0, 1);

        // parity variants and two stop bits
        ptype = 2'b01; push_word(8'h3C); wait_drain(400);
        ptype = 2'b10; push_word(8'h3C); wait_drain(400);
        ptype = 2'b00; stop2 = 1'b1; push_word(8'h3C); wait_drain(400);
        stop2 = 1'b0;

        // fill the FIFO from idle, then hold a write while full
        d0 = done_cnt;
        for (int i = 0; i < 17; i++) push_word(8'($urandom));
        check("full_count", 32'(count_a), 16);
        check("full_flag", 32'(full_a), 1);
        check("full_ready", 32'(ready_a), 0);
        s_data = 8'hFF; s_valid = 1'b1;
        repeat (5) @(negedge clk);
        s_valid = 1'b0;
        wait_drain(4000);
        check("burst_done_count", done_cnt - d0, 17);

        // reset in the middle of data bit 3 with words still queued
        push_word(8'h55); push_word(8'h0F); push_word(8'hF0);
        wait_pos(4 * 16 + 4, 400);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_tx", 32'(tx_a), 1);
        check("midrst_count", 32'(count_a), 0);
        check("midrst_empty", 32'(empty_a), 1);
        check("midrst_active", 32'(act_a), 0);
        check("midrst_done", 32'(done_a), 0);
        @(negedge clk);
        reset = 1'b0;
        d0 = done_cnt;
        repeat (300) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_idle_tx", 32'(tx_a), 1);

        // randomized batches with random configuration and push spacing
        for (int bt = 0; bt < 6; bt++) begin
            ptype = 2'($urandom_range(0, 3));
            stop2 = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                push_word(8'($urandom));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_drain(n * 13 * 16 + 300);
        end

        // second instance: real divisors from the baud table, 7 data bits, depth 4
        sel_b = 1'b1;
        ptype = 2'b00; stop2 = 1'b0; bsel = 2'b11;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) push_word(8'($urandom));
        check("b_full_count", 32'(count_b), 4);
        check("b_full_flag", 32'(full_b), 1);
        check("b_full_ready", 32'(ready_b), 0);
        wait_drain(5 * 13 * 52 + 300);
        for (int bt = 0; bt < 3; bt++) begin
            ptype = 2'($urandom_range(0, 3));
            stop2 = 1'($urandom_range(0, 1));
            bsel  = 2'($urandom_range(0, 3));
            push_word(8'($urandom));
            push_word(8'($urandom));
            wait_drain(2 * 12 * 417 + 500);
        end

        // baud change mid-frame must not disturb the frame already on the line
        ptype = 2'b00; stop2 = 1'b0; bsel = 2'b10;
        push_word(8'h96);
        wait_pos(3 * 104 + 10, 1000);
        bsel = 2'b00;
        wait_drain(12 * 104 + 500);
        bsel = 2'b10;

        check("idle_active_low", idle_act_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
